// File: rtl/hilo_div_unit_pkg.sv
// Shared types and constants for the HI/LO divide unit: FSM state encoding,
// iteration count and operand magnitude helper.
package hilo_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } divState_t;

    localparam int unsigned DIV_ITERATIONS = 32;

    function automatic logic [31:0] opMagnitude(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One combinational restoring-division step: shift the partial remainder left by one
// dividend bit, trial-subtract the divisor, keep the difference when it does not underflow.
module div_step
    import hilo_div_unit_pkg::*;
(
    input  logic [32:0] remIn,
    input  logic        dividendBit,
    input  logic [31:0] divisor,
    output logic [32:0] remOut,
    output logic        qBit
);

    logic [33:0] shifted;

    assign shifted = {remIn, dividendBit};
    assign qBit    = (shifted >= {2'b00, divisor});
    assign remOut  = 33'(qBit ? (shifted - {2'b00, divisor}) : shifted);

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative div/divu unit owning architectural HI/LO (32 restoring steps plus a sign-fix cycle).
// Optional mthi/mtlo write path is enabled by defining HILO_MOVE_EN.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        StartDivE,
    input  logic        SignedE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        FlushE,
`ifdef HILO_MOVE_EN
    input  logic        MtHiE,
    input  logic        MtLoE,
`endif
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        DivBusy,
    output logic        DivDone
);

    divState_t   state;
    logic [32:0] rem;
    logic [31:0] quot;
    logic [31:0] divisor;
    logic        quotNeg;
    logic        remNeg;
    logic [5:0]  iter;

    logic [32:0] stepRem;
    logic        stepQ;
    logic        startOk;

    assign startOk = StartDivE & FlushE;
    assign DivBusy = (state != IDLE);

`ifdef HILO_MOVE_EN
    logic moveHi;
    logic moveLo;

    assign moveHi = MtHiE & FlushE;
    assign moveLo = MtLoE & FlushE;
`endif

    div_step uStep (
        .remIn       (rem),
        .dividendBit (quot[31]),
        .divisor     (divisor),
        .remOut      (stepRem),
        .qBit        (stepQ)
    );

    // quot doubles as the dividend shift register: each step consumes its MSB
    // and shifts a quotient bit in at the bottom.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            quotNeg <= 1'b0;
            remNeg  <= 1'b0;
            iter    <= '0;
            HiOut   <= '0;
            LoOut   <= '0;
            DivDone <= 1'b0;
        end else begin
            DivDone <= 1'b0;
`ifdef HILO_MOVE_EN
            if (moveHi || moveLo) begin
                if (moveHi) HiOut <= SrcAE;
                if (moveLo) LoOut <= SrcAE;
                state <= IDLE;
                iter  <= '0;
            end else
`endif
            if (startOk) begin
                iter <= '0;
                if (SrcBE == '0) begin
                    // Divide-by-zero reuses the FIX write path with unsigned results preloaded.
                    rem     <= {1'b0, SrcAE};
                    quot    <= '1;
                    divisor <= '0;
                    quotNeg <= 1'b0;
                    remNeg  <= 1'b0;
                    state   <= FIX;
                end else begin
                    rem     <= '0;
                    quot    <= opMagnitude(SrcAE, SignedE);
                    divisor <= opMagnitude(SrcBE, SignedE);
                    quotNeg <= SignedE & (SrcAE[31] ^ SrcBE[31]);
                    remNeg  <= SignedE & SrcAE[31];
                    state   <= RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        rem  <= stepRem;
                        quot <= {quot[30:0], stepQ};
                        iter <= iter + 6'd1;
                        if (iter == 6'(DIV_ITERATIONS - 1)) state <= FIX;
                    end
                    FIX: begin
                        LoOut   <= quotNeg ? -quot : quot;
                        HiOut   <= remNeg ? -rem[31:0] : rem[31:0];
                        DivDone <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
